// File: rtl/shift_reg_piso_tx_if.sv
// Parallel-word and serial-beat handshake bundle for shift_reg_piso_tx.
// master = word source / serial sink side, slave = the transmitter.
interface shift_reg_piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_valid;
  logic             ser_out;
  logic             ser_last;
  logic             ser_ready;
  logic             busy;

  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_last, busy
  );

  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, ser_last, busy
  );
endinterface

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready on both sides.
// Optional even-parity trailer beat enabled by defining PISO_TX_PARITY_EN.
module shift_reg_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  shift_reg_piso_tx_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned BEATS = WIDTH + 1;
`else
  localparam int unsigned BEATS = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             data_bit;
  logic             tx_bit;
  logic             beat;
  logic             load;

`ifdef PISO_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^bus.in_data;
    end
  end

  // Data is fully shifted out by the parity beat, so the bit source switches.
  always_comb begin
    tx_bit = data_bit;
    if (cnt == CW'(WIDTH)) tx_bit = parity;
  end
`else
  always_comb begin
    tx_bit = data_bit;
  end
`endif

  always_comb begin
    data_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    bus.ser_valid = (state == SHIFT);
    bus.busy      = (state == SHIFT);
    bus.ser_last  = (state == SHIFT) && (cnt == LAST_IDX);
    bus.ser_out   = (state == SHIFT) && tx_bit;
    beat          = bus.ser_valid && bus.ser_ready;
    bus.in_ready  = (state == IDLE) || (beat && bus.ser_last);
    load          = bus.in_valid && bus.in_ready;
  end

  // A load on the final-beat edge takes priority over the shift/idle return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      state <= SHIFT;
      shreg <= bus.in_data;
      cnt   <= '0;
    end else if (beat) begin
      if (MSB_FIRST) shreg <= {shreg[WIDTH-2:0], 1'b0};
      else           shreg <= {1'b0, shreg[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (bus.ser_last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share stimulus;
// accepted words become expected beat lists checked by per-lane monitors.
module tb_shift_reg_piso_tx;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic b;
    logic last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         ser_ready;
  logic         rmode;
  logic         accepted;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t q0[$];
  beat_t q1[$];

  always #5 clk = ~clk;

  shift_reg_piso_tx_if #(.WIDTH(W)) if0 ();
  shift_reg_piso_tx_if #(.WIDTH(W)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.ser_ready = ser_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.ser_ready = ser_ready;

  shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(if0));
  shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame = data bits in transmit order, then optional even parity.
  task automatic push_word(input logic [W-1:0] w);
    beat_t e;
    for (int i = 0; i < W; i++) begin
      e.last = (i == W - 1) && !PAR;
      e.b = w[W-1-i];
      q0.push_back(e);
      e.b = w[i];
      q1.push_back(e);
    end
    if (PAR) begin
      e.b = ^w;
      e.last = 1'b1;
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  function automatic int qsize(input int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qhead(input int l);
    return (l == 0) ? q0[0] : q1[0];
  endfunction

  task automatic mon(input int l, input logic sv, input logic so, input logic sl,
                     input logic ir, input logic bz);
    beat_t h;
    logic  exp_v;
    string p;
    if (rst_n !== 1'b1) return;
    p = (l == 0) ? "msb" : "lsb";
    exp_v = qsize(l) > 0;
    chk({p, ".ser_valid"}, sv, exp_v);
    chk({p, ".busy"}, bz, exp_v);
    if (exp_v) begin
      h = qhead(l);
      chk({p, ".in_ready"}, ir, ser_ready && h.last);
      chk({p, ".ser_out"}, so, h.b);
      chk({p, ".ser_last"}, sl, h.last);
      if (ser_ready) begin
        if (l == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end else begin
      chk({p, ".in_ready"}, ir, 1'b1);
      chk({p, ".ser_out_idle"}, so, 1'b0);
      chk({p, ".ser_last_idle"}, sl, 1'b0);
    end
  endtask

  always @(negedge clk) mon(0, if0.ser_valid, if0.ser_out, if0.ser_last, if0.in_ready, if0.busy);
  always @(negedge clk) mon(1, if1.ser_valid, if1.ser_out, if1.ser_last, if1.in_ready, if1.busy);

  // One clock: sample handshake away from the edge, record accept at the edge.
  task automatic cycle();
    logic         acc;
    logic [W-1:0] d;
    @(negedge clk);
    acc = rst_n && in_valid && if0.in_ready;
    d = in_data;
    @(posedge clk);
    accepted = acc;
    if (acc) push_word(d);
    #1;
    if (rmode) ser_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data = w;
    accepted = 1'b0;
    for (int n = 0; n < 60 && !accepted; n++) cycle();
    chk("word_accept_timeout", accepted, 1'b1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 100 && (q0.size() + q1.size()) != 0; n++) cycle();
    cycle();
    chk("drain_timeout", (q0.size() + q1.size()) == 0, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".ser_valid"}, if0.ser_valid | if1.ser_valid, 1'b0);
    chk({tag, ".busy"}, if0.busy | if1.busy, 1'b0);
    chk({tag, ".in_ready"}, if0.in_ready & if1.in_ready, 1'b1);
    chk({tag, ".ser_out"}, if0.ser_out | if1.ser_out, 1'b0);
    chk({tag, ".ser_last"}, if0.ser_last | if1.ser_last, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    ser_ready = 1'b1;
    rmode = 1'b0;
    accepted = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;

    // Basic frame; in_data changes after accept must not affect it.
    send_word(4'b1111);
    in_data = 4'b0000;
    drain();
    send_word(4'b1011);
    drain();

    // Stall three cycles on the second beat.
    send_word(4'b0110);
    in_valid = 1'b0;
    cycle();
    ser_ready = 1'b0;
    repeat (3) cycle();
    ser_ready = 1'b1;
    drain();

    // Back-to-back with in_valid held.
    send_word(4'b1100);
    send_word(4'b0011);
    drain();

    // Reset after two beats, with a word waiting during reset.
    send_word(4'b1011);
    in_valid = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    q0.delete();
    q1.delete();
    in_valid = 1'b1;
    in_data = 4'b1001;
    repeat (2) cycle();
    rst_n = 1'b1;
    send_word(4'b1001);
    drain();
    send_word(4'b1001);
    drain();

    // Randomized words, gaps and serial stalls.
    rmode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_word(W'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 6)) cycle();
      end
    end
    drain();
    rmode = 1'b0;
    ser_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
